pwm_duty_meter: RTL

Downstream monitor for the PWM generator output. It samples a PWM waveform on the system clock and measures high time and period in clock cycles. It then computes the duty cycle in tenths (0-10) using a sequential divider and reports each result with a one-cycle valid strobe. It also flags a waveform stuck high or stuck low, so the bench and on-chip readback can confirm that the duty inc/dec buttons took effect.

---
 rtl/pwm_duty_meter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_meter.sv
// PWM duty-cycle meter: synchronises a PWM input, measures high time and
// period in clk cycles, divides by repeated addition to get duty in tenths,
// and flags a waveform that has stopped toggling.
module pwm_duty_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [3:0]       duty_tenths,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             busy
);

  localparam int ACC_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] TO_CNT    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_CNT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_dly;
  logic [CNT_W-1:0]   r_hcnt;
  logic [CNT_W-1:0]   r_lcnt;
  logic [CNT_W-1:0]   r_run;
  logic [CNT_W-1:0]   r_h;
  logic [CNT_W:0]     r_p;
  logic [ACC_W-1:0]   r_target;
  logic [ACC_W-1:0]   r_acc;
  logic [3:0]         r_q;
  logic [CNT_W-1:0]   r_high_cnt;
  logic [CNT_W-1:0]   r_period_cnt;
  logic [3:0]         r_duty;
  logic               r_valid;
  logic               r_stuck_h;
  logic               r_stuck_l;

  logic               w_s;
  logic               w_rise;
  logic               w_fall;
  logic [CNT_W:0]     w_p_sum;
  logic [ACC_W-1:0]   w_target;
  logic [ACC_W-1:0]   w_acc_init;
  logic [ACC_W-1:0]   w_acc_next;
  logic [CNT_W-1:0]   w_p_sat;
  logic               w_calc_step;

  // Edge detection on the synchronised level; the 2-cycle lag cancels because
  // both ends of every measured interval are taken from the same edge detector.
  assign w_s    = r_sync2;
  assign w_rise = r_sync2 & ~r_dly;
  assign w_fall = ~r_sync2 & r_dly;

  // Period is one bit wider than the counters: high and low can each reach TIMEOUT.
  assign w_p_sum     = {1'b0, r_hcnt} + {1'b0, r_lcnt};
  assign w_target    = ({4'b0000, r_hcnt} << 3) + ({4'b0000, r_hcnt} << 1);
  assign w_acc_init  = {3'b000, w_p_sum};
  assign w_acc_next  = r_acc + {3'b000, r_p};
  assign w_p_sat     = r_p[CNT_W] ? {CNT_W{1'b1}} : r_p[CNT_W-1:0];
  assign w_calc_step = (r_acc <= r_target) && (r_q < 4'd10);

  assign high_cnt    = r_high_cnt;
  assign period_cnt  = r_period_cnt;
  assign duty_tenths = r_duty;
  assign meas_valid  = r_valid;
  assign stuck_high  = r_stuck_h;
  assign stuck_low   = r_stuck_l;
  assign busy        = (r_state != S_IDLE);

  // Two-flop synchroniser for the asynchronous pin, plus one delay flop for edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  // Measurement FSM: arm on a rise, count high and low, divide, publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hcnt       <= '0;
      r_lcnt       <= '0;
      r_run        <= '0;
      r_h          <= '0;
      r_p          <= '0;
      r_target     <= '0;
      r_acc        <= '0;
      r_q          <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_duty       <= '0;
      r_valid      <= 1'b0;
      r_stuck_h    <= 1'b0;
      r_stuck_l    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if ((r_state != S_IDLE) && !meas_en) begin
        // Abort: discard the measurement in progress, keep published results.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (meas_en) begin
              r_run   <= '0;
              r_state <= S_ARM;
            end
          end
          S_ARM: begin
            if (w_rise) begin
              r_hcnt    <= CNT_ONE;
              r_stuck_h <= 1'b0;
              r_stuck_l <= 1'b0;
              r_state   <= S_HIGH;
            end else if (w_fall) begin
              r_run <= '0;
            end else if (r_run >= TO_CNT_M1) begin
              // Level has not changed for TIMEOUT cycles; flag it and keep watching.
              if (w_s) begin
                r_stuck_h <= 1'b1;
              end else begin
                r_stuck_l <= 1'b1;
              end
              r_run <= '0;
            end else begin
              r_run <= r_run + CNT_ONE;
            end
          end
          S_HIGH: begin
            if (w_fall) begin
              r_lcnt  <= CNT_ONE;
              r_state <= S_LOW;
            end else if (r_hcnt >= TO_CNT) begin
              r_stuck_h <= 1'b1;
              r_run     <= '0;
              r_state   <= S_ARM;
            end else begin
              r_hcnt <= r_hcnt + CNT_ONE;
            end
          end
          S_LOW: begin
            if (w_rise) begin
              r_h      <= r_hcnt;
              r_p      <= w_p_sum;
              r_target <= w_target;
              r_acc    <= w_acc_init;
              r_q      <= 4'd0;
              r_state  <= S_CALC;
            end else if (r_lcnt >= TO_CNT) begin
              r_stuck_l <= 1'b1;
              r_run     <= '0;
              r_state   <= S_ARM;
            end else begin
              r_lcnt <= r_lcnt + CNT_ONE;
            end
          end
          S_CALC: begin
            // q counts how many multiples of P fit under 10*H.
            if (w_calc_step) begin
              r_q   <= r_q + 4'd1;
              r_acc <= w_acc_next;
            end else begin
              r_high_cnt   <= r_h;
              r_period_cnt <= w_p_sat;
              r_duty       <= r_q;
              r_valid      <= 1'b1;
              r_state      <= S_DONE;
            end
          end
          S_DONE: begin
            r_run   <= '0;
            r_state <= S_ARM;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
